// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: BRAM read port plus the valid/ready instruction
// handshake toward decode. master = fetch unit side, slave = environment side.
interface fetch_unit_if #(
  parameter int ADDR_W = 18
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_ready;

  modport master (
    output mem_en, mem_addr, inst_valid, inst, inst_pc,
    input  mem_rdata, inst_ready
  );

  modport slave (
    input  mem_en, mem_addr, inst_valid, inst, inst_pc,
    output mem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues 1-cycle-latency BRAM reads, optionally
// byte-reverses each word, and buffers PC-tagged words for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          ADDR_W     = 18
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        enable,
  input  logic                        little_endian,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  fetch_unit_if.master                bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int OCC_W = LVL_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    swap_bytes = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [31:0]        fetch_pc_r;
  logic [31:0]        fetch_pc_nxt_s;
  logic [31:0]        resp_pc_r;
  logic               in_flight_r;
  logic               kill_r;

  logic [31:0]        data_mem_r [FIFO_DEPTH];
  logic [31:0]        pc_mem_r   [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [PTR_W-1:0]   wr_ptr_nxt_s;
  logic [LVL_W-1:0]   count_r;
  logic [LVL_W-1:0]   count_nxt_s;
  logic [LVL_W-1:0]   remain_s;

  logic               inst_valid_r;
  logic [31:0]        inst_r;
  logic [31:0]        inst_pc_r;
  logic               head_valid_nxt_s;
  logic [31:0]        head_data_nxt_s;
  logic [31:0]        head_pc_nxt_s;

  logic               pop_s;
  logic               push_s;
  logic               flush_s;
  logic               issue_s;
  logic [OCC_W-1:0]   occ_s;
  logic [31:0]        push_data_s;

  assign bus.mem_en     = issue_s;
  assign bus.mem_addr   = fetch_pc_r[ADDR_W+1:2];
  assign bus.inst_valid = inst_valid_r;
  assign bus.inst       = inst_r;
  assign bus.inst_pc    = inst_pc_r;
  assign fifo_level     = count_r;

  // Run/idle next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_nxt_s = RUN;
        else        state_nxt_s = IDLE;
      end
      RUN: begin
        if (enable) state_nxt_s = RUN;
        else        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Issue, FIFO pointer and head-register next-state logic
  always_comb begin
    pop_s       = inst_valid_r && bus.inst_ready;
    flush_s     = redirect_valid && (state_r == RUN);
    // A pop in the flush cycle is simply swallowed by the clear
    push_s      = in_flight_r && !kill_r && !flush_s;
    occ_s       = OCC_W'(count_r) + OCC_W'(in_flight_r) - OCC_W'(pop_s);
    issue_s     = (state_r == RUN) && !redirect_valid && (occ_s < OCC_W'(FIFO_DEPTH));
    push_data_s = little_endian ? swap_bytes(bus.mem_rdata) : bus.mem_rdata;

    if (redirect_valid) begin
      fetch_pc_nxt_s = redirect_pc & 32'hFFFF_FFFC;
    end else if (issue_s) begin
      fetch_pc_nxt_s = fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_nxt_s = fetch_pc_r;
    end

    if (flush_s) begin
      count_nxt_s  = {LVL_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      wr_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      count_nxt_s  = count_r + LVL_W'(push_s) - LVL_W'(pop_s);
      rd_ptr_nxt_s = pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      wr_ptr_nxt_s = push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
    end

    // When nothing survives the pop, the new head is the word arriving now
    remain_s = count_r - LVL_W'(pop_s);
    if (count_nxt_s == {LVL_W{1'b0}}) begin
      head_valid_nxt_s = 1'b0;
      head_data_nxt_s  = inst_r;
      head_pc_nxt_s    = inst_pc_r;
    end else if (remain_s == {LVL_W{1'b0}}) begin
      head_valid_nxt_s = 1'b1;
      head_data_nxt_s  = push_data_s;
      head_pc_nxt_s    = resp_pc_r;
    end else begin
      head_valid_nxt_s = 1'b1;
      head_data_nxt_s  = data_mem_r[rd_ptr_nxt_s];
      head_pc_nxt_s    = pc_mem_r[rd_ptr_nxt_s];
    end
  end

  // Control, PC and head-of-queue registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r      <= IDLE;
      fetch_pc_r   <= RESET_PC;
      resp_pc_r    <= 32'h0000_0000;
      in_flight_r  <= 1'b0;
      kill_r       <= 1'b0;
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {LVL_W{1'b0}};
      inst_valid_r <= 1'b0;
      inst_r       <= 32'h0000_0000;
      inst_pc_r    <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      fetch_pc_r   <= fetch_pc_nxt_s;
      if (issue_s) resp_pc_r <= fetch_pc_r;
      in_flight_r  <= issue_s;
      kill_r       <= flush_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      count_r      <= count_nxt_s;
      inst_valid_r <= head_valid_nxt_s;
      inst_r       <= head_data_nxt_s;
      inst_pc_r    <= head_pc_nxt_s;
    end
  end

  // Prefetch storage
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]   <= 32'h0000_0000;
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r] <= push_data_s;
      pc_mem_r[wr_ptr_r]   <= resp_pc_r;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the CPU's decode/execute sequencer.
- Reads 32-bit instruction words from the instruction BRAM, which has a synchronous read with 1-cycle latency.
- Applies optional little-endian byte reordering, tags each word with its byte PC and buffers it in a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake. Branch redirect flushes the buffer and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, at least 2.
- ADDR_W, 18, BRAM word-address width.

Ports:
- clk  in  1  clock, rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- enable  in  1  fetch permitted; level-sensitive.
- little_endian  in  1  1 = byte-reverse each fetched word.
- mem_en  out  1  BRAM read enable.
- mem_addr  out  ADDR_W  BRAM word address, equal to fetch_pc[ADDR_W+1:2].
- mem_rdata  in  32  BRAM read data, valid the cycle after mem_en.
- redirect_valid  in  1  branch/exception redirect, one-cycle pulse.
- redirect_pc  in  32  redirect byte target; bits [1:0] are ignored (forced to 0).
- inst_valid  out  1  FIFO head valid.
- inst  out  32  instruction word at FIFO head (big-endian order).
- inst_pc  out  32  byte address of inst.
- inst_ready  in  1  decode accepts head; a pop occurs when inst_valid && inst_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- Reset (asynchronous, while n_reset=0):
  - fetch_pc=RESET_PC; state=IDLE; FIFO empty; in_flight=0; kill=0.
  - Outputs: mem_en=0, mem_addr=RESET_PC[ADDR_W+1:2], inst_valid=0, inst=0, inst_pc=0, fifo_level=0.
- Reset mid-operation: the outstanding BRAM response is dropped. The first fetch after release is from RESET_PC.
- State machine:
  - IDLE -> RUN when enable=1 at a clock edge.
  - RUN -> IDLE when enable=0 at a clock edge.
  - Leaving RUN does not cancel an in-flight read; its response is still written to the FIFO.
  - FIFO contents persist in IDLE and may still be popped.
- Issue rule (combinational):
  - mem_en = (state==RUN) && !redirect_valid && (fifo_level + in_flight - pop < FIFO_DEPTH).
  - On issue: fetch_pc <= fetch_pc+4, wrapping modulo 2^32; in_flight <= 1; the issuing PC is captured as resp_pc.
  - No issue -> in_flight <= 0.
  - At most one request per cycle.
- Response:
  - When in_flight=1 and kill=0, mem_rdata is written to the FIFO tail with resp_pc.
  - little_endian=1 -> {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]}; otherwise rdata unchanged. little_endian is sampled at capture.
- Latency: enable sampled at edge E0 -> first mem_en during cycle E0..E1 -> inst_valid=1 after edge E2.
- Throughput: with inst_ready held at 1, one instruction per cycle, consecutive PCs +4, no bubbles.
- Output timing: inst, inst_pc and inst_valid are registered/FIFO-head outputs and hold stable while inst_valid && !inst_ready.
- Redirect (sampled at edge R):
  - FIFO cleared; fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - An in-flight response arriving in cycle R..R+1 is discarded via kill.
  - A pop in the same cycle is absorbed into the flush, with no error.
  - No issue occurs in the redirect cycle. First issue is in cycle R..R+1; inst_valid with inst_pc = target after edge R+2.
  - Redirect in IDLE updates fetch_pc only.
  - Back-to-back redirects: the last one wins.
- Full FIFO: the issue rule stalls the BRAM; the FIFO never overflows.
- Empty FIFO: inst_valid=0; inst and inst_pc hold their last values.
- Simultaneous push and pop on a non-empty FIFO: fifo_level is unchanged.
- Address wrap: fetch_pc 0xFFFF_FFFC -> 0x0000_0000. mem_addr aliases through the truncated bits.

Test Plan:
- Reset, enable=1, BRAM words 0..3 = 0xE3A00001, 0xE3A01002, 0xE0802001, 0xEAFFFFFE, inst_ready=1 -> inst_valid after second edge; inst sequence equals the words in order; inst_pc 0x0, 0x4, 0x8, 0xC; one instruction per cycle.
- little_endian=1, word 0 = 0x0100A0E3 -> inst=0xE3A00001, inst_pc=0x0.
- inst_ready=0 for 6 cycles -> fifo_level saturates at FIFO_DEPTH; mem_en=0; head stays 0xE3A00001 at pc 0x0. Release -> next inst_pc 0x4 with no word lost or duplicated.
- Redirect 0x0000_0043 while a read is in flight and the FIFO holds 2 entries -> fifo_level=0 next cycle; the stale response is dropped; next inst_pc=0x40 two cycles after the redirect edge.
- enable drops with one read outstanding -> that word still appears (inst_pc=0x8); no further mem_en. enable re-asserted -> fetch resumes at 0xC.
- Assert n_reset low mid-stream with the FIFO full -> all outputs 0 immediately. After release and enable -> first inst_pc = RESET_PC.
